mul_bus_ctrl: RTL and testbench

//  Bus-slave register front end and sequencer for the 32x32 signed radix-2 Booth multiplier core.

---
 rtl/mul_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_mul_bus_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_bus_ctrl.sv
// rtl/mul_bus_ctrl.sv - register bus front end and sequencer for the 32x32 signed Booth multiplier core
module mul_bus_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [2:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        m_interrupt,
    output logic [31:0] mcand,
    output logic [31:0] mplier,
    output logic        op_start,
    output logic        op_clear,
    input  logic        op_done,
    input  logic [63:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] CAPT = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_state;
    logic [31:0]   r_mcand;
    logic [31:0]   r_mplier;
    logic          r_int_en;
    logic          r_done;
    logic          r_terr;
    logic [63:0]   r_res;
    logic [TW-1:0] r_timer;

    logic w_wr;
    logic w_idle;
    logic w_start;
    logic w_clear;

    assign w_wr    = s_sel & s_wr;
    assign w_idle  = (r_state == IDLE);
    assign w_start = w_wr && (s_addr == 3'd0) && s_din[0] && w_idle;
    assign w_clear = w_wr && (s_addr == 3'd1) && s_din[0];

    // Operand and enable registers are frozen while an operation is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= 32'h0;
            r_mplier <= 32'h0;
            r_int_en <= 1'b0;
        end else if (w_wr && w_idle) begin
            case (s_addr)
                3'd3:    r_mcand  <= s_din;
                3'd4:    r_mplier <= s_din;
                3'd7:    r_int_en <= s_din[0];
                default: ;
            endcase
        end
    end

    // CLEAR overrides every state transition, including a same-cycle op_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_res   <= 64'h0;
            r_timer <= '0;
        end else if (w_clear) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_res   <= 64'h0;
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= LOAD;
                        r_done  <= 1'b0;
                        r_terr  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                    r_timer <= '0;
                end
                RUN: begin
                    if (op_done) begin
                        r_state <= CAPT;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_state <= IDLE;
                        r_terr  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                CAPT: begin
                    r_res   <= result;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign op_start    = (r_state == LOAD);
    assign op_clear    = w_idle;
    assign mcand       = r_mcand;
    assign mplier      = r_mplier;
    assign m_interrupt = r_done & r_int_en;

    always_comb begin
        s_dout = 32'h0;
        if (s_sel && !s_wr) begin
            case (s_addr)
                3'd2:    s_dout = {29'h0, r_terr, ~w_idle, r_done};
                3'd3:    s_dout = r_mcand;
                3'd4:    s_dout = r_mplier;
                3'd5:    s_dout = r_res[31:0];
                3'd6:    s_dout = r_res[63:32];
                3'd7:    s_dout = {31'h0, r_int_en};
                default: s_dout = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_bus_ctrl.sv
// tb/tb_mul_bus_ctrl.sv - self-checking bench for mul_bus_ctrl with a behavioural Booth core model
module tb_mul_bus_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_sel = 1'b0;
    logic        s_wr = 1'b0;
    logic [2:0]  s_addr = 3'd0;
    logic [31:0] s_din = 32'h0;
    logic [31:0] s_dout;
    logic        m_interrupt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        op_start;
    logic        op_clear;
    logic        op_done;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;
    int both_hi = 0;
    logic hang = 1'b0;
    logic [63:0] exp_q[$];

    mul_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(s_dout), .m_interrupt(m_interrupt), .mcand(mcand),
        .mplier(mplier), .op_start(op_start), .op_clear(op_clear), .op_done(op_done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Core model: fixed 32-cycle latency, op_done one cycle, result held.
    logic       core_busy;
    logic [5:0] core_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_busy <= 1'b0;
            core_cnt  <= 6'd0;
            op_done   <= 1'b0;
            result    <= 64'h0;
        end else begin
            op_done <= 1'b0;
            if (op_clear) begin
                core_busy <= 1'b0;
            end else if (op_start) begin
                core_busy <= 1'b1;
                core_cnt  <= 6'd0;
                result    <= {{32{mcand[31]}}, mcand} * {{32{mplier[31]}}, mplier};
            end else if (core_busy && !hang) begin
                core_cnt <= core_cnt + 6'd1;
                if (core_cnt == 6'd31) begin
                    op_done   <= 1'b1;
                    core_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (op_start && op_clear) both_hi++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk);
        #1;
        s_sel = 1'b0; s_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1;
        d = s_dout;
        s_sel = 1'b0;
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        logic [31:0] st, lo, hi;
        logic [63:0] want;
        int lat;
        bus_wr(3'd3, a);
        bus_wr(3'd4, b);
        exp_q.push_back(e);
        bus_wr(3'd0, 32'h1);
        lat = 0;
        st = 32'h0;
        while (lat < 100 && !st[0]) begin
            bus_rd(3'd2, st);
            lat++;
        end
        chk("done_seen", {63'h0, st[0]}, 64'h1);
        chk("latency_ok", {63'h0, lat <= TIMEOUT + 2}, 64'h1);
        chk("status_done", {32'h0, st}, 64'h1);
        bus_rd(3'd5, lo);
        bus_rd(3'd6, hi);
        want = exp_q.pop_front();
        chk("result", {hi, lo}, want);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a, b;
        int n;

        #1;
        chk("rst_op_clear", {63'h0, op_clear}, 64'h1);
        chk("rst_op_start", {63'h0, op_start}, 64'h0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        bus_rd(3'd2, rd);
        chk("rst_status", {32'h0, rd}, 64'h0);
        bus_rd(3'd5, rd);
        chk("rst_res_lo", {32'h0, rd}, 64'h0);

        run_op(32'd3, 32'd5, 64'd15);

        bus_wr(3'd7, 32'hFFFF_FFFF);
        bus_rd(3'd7, rd);
        chk("int_en_rd", {32'h0, rd}, 64'h1);
        run_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("irq_set", {63'h0, m_interrupt}, 64'h1);
        bus_wr(3'd1, 32'h1);
        chk("irq_clr", {63'h0, m_interrupt}, 64'h0);
        bus_rd(3'd5, rd);
        chk("clear_res", {32'h0, rd}, 64'h0);

        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            run_op(a, b, smul(a, b));
        end
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

        // Abort mid-run: busy writes ignored, CLEAR wipes status and result
        bus_wr(3'd0, 32'h1);
        repeat (5) @(posedge clk);
        bus_wr(3'd3, 32'd9);
        repeat (4) @(posedge clk);
        bus_wr(3'd1, 32'h1);
        chk("abort_op_clear", {63'h0, op_clear}, 64'h1);
        chk("abort_op_start", {63'h0, op_start}, 64'h0);
        chk("abort_mcand_port", {32'h0, mcand}, 64'h7FFF_FFFF);
        bus_rd(3'd3, rd);
        chk("abort_mcand_reg", {32'h0, rd}, 64'h7FFF_FFFF);
        bus_rd(3'd2, rd);
        chk("abort_status", {32'h0, rd}, 64'h0);
        bus_rd(3'd6, rd);
        chk("abort_res_hi", {32'h0, rd}, 64'h0);

        // Timeout: RES kept from previous op, LOAD + TIMEOUT RUN cycles busy
        run_op(32'd7, 32'd11, 64'd77);
        hang = 1'b1;
        bus_wr(3'd0, 32'h1);
        n = 0;
        rd = 32'h2;
        while (n < 200 && rd[1]) begin
            bus_rd(3'd2, rd);
            if (rd[1]) n++;
        end
        chk("to_busy_cycles", 64'(n), 64'(TIMEOUT + 1));
        chk("to_status", {32'h0, rd}, 64'h4);
        bus_rd(3'd5, rd);
        chk("to_res_kept", {32'h0, rd}, 64'd77);
        hang = 1'b0;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        // Asynchronous reset during RUN
        bus_wr(3'd0, 32'h1);
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_op_clear", {63'h0, op_clear}, 64'h1);
        chk("ar_op_start", {63'h0, op_start}, 64'h0);
        chk("ar_mcand", {32'h0, mcand}, 64'h0);
        chk("ar_mplier", {32'h0, mplier}, 64'h0);
        chk("ar_irq", {63'h0, m_interrupt}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(3'd2, rd);
        chk("ar_status", {32'h0, rd}, 64'h0);
        bus_rd(3'd7, rd);
        chk("ar_int_en", {32'h0, rd}, 64'h0);
        run_op(32'd2, 32'd2, 64'd4);

        chk("never_start_and_clear", 64'(both_hi), 64'h0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
